// File: rtl/mc_control_unit_if.sv
// Control bundle between mc_control_unit (master) and the multicycle datapath (slave).
// Carries the IR opcode, ALU zero flag, memory-ready handshake and every control strobe.
interface mc_control_unit_if #(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 3
);
   logic [OP_W-1:0]    opcode;
   logic               zero;
   logic               mem_ready;
   logic [2:0]         state;
   logic               PCWre;
   logic               InsMemRW;
   logic               IRWre;
   logic               WrRegData;
   logic               RegWre;
   logic               ALUSrcA;
   logic               ALUSrcB;
   logic               DataMemRW;
   logic               DBDataSrc;
   logic [1:0]         ExtSel;
   logic [1:0]         RegDst;
   logic [1:0]         PCSrc;
   logic [ALUOP_W-1:0] ALUOp;
   logic               halted;
   logic               illegal;

   modport master (
      input  opcode, zero, mem_ready,
      output state, PCWre, InsMemRW, IRWre, WrRegData, RegWre, ALUSrcA, ALUSrcB,
             DataMemRW, DBDataSrc, ExtSel, RegDst, PCSrc, ALUOp, halted, illegal
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  state, PCWre, InsMemRW, IRWre, WrRegData, RegWre, ALUSrcA, ALUSrcB,
             DataMemRW, DBDataSrc, ExtSel, RegDst, PCSrc, ALUOp, halted, illegal
   );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle CPU control unit: phase FSM plus state/opcode decode of all datapath strobes.
// Optional feature: define MCCTRL_JAL_EN to decode jal; otherwise jal is treated as illegal.
module mc_control_unit #(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 3
) (
   input  logic               CLK,
   input  logic               Reset,
   mc_control_unit_if.master  bus
);

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_AEXE = 3'b110,
      S_BEXE = 3'b101,
      S_CEXE = 3'b010,
      S_MEM  = 3'b011,
      S_AWB  = 3'b111,
      S_CWB  = 3'b100
   } state_t;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SLT  = 6'b100110;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_BNE  = 6'b110101;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_JAL  = 6'b111010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   state_t     state_q;
   state_t     state_d;
   logic       halted_q;
   logic [5:0] op6;
   logic       upper_zero;
   logic       is_add, is_sub, is_addi, is_or, is_ori, is_slt;
   logic       is_sw, is_lw, is_beq, is_bne, is_j, is_jal, is_halt;
   logic       is_illegal;
   logic       jump_id;
   logic       reg_wre;
   logic [2:0] alu_code;

   assign op6 = bus.opcode[5:0];

   // Any set bit above the 6-bit opcode field makes the instruction undecodable.
   generate
      if (OP_W > 6) begin : g_upper
         assign upper_zero = (bus.opcode[OP_W-1:6] == '0);
      end else begin : g_no_upper
         assign upper_zero = 1'b1;
      end
   endgenerate

   assign is_add  = upper_zero && (op6 == OP_ADD);
   assign is_sub  = upper_zero && (op6 == OP_SUB);
   assign is_addi = upper_zero && (op6 == OP_ADDI);
   assign is_or   = upper_zero && (op6 == OP_OR);
   assign is_ori  = upper_zero && (op6 == OP_ORI);
   assign is_slt  = upper_zero && (op6 == OP_SLT);
   assign is_sw   = upper_zero && (op6 == OP_SW);
   assign is_lw   = upper_zero && (op6 == OP_LW);
   assign is_beq  = upper_zero && (op6 == OP_BEQ);
   assign is_bne  = upper_zero && (op6 == OP_BNE);
   assign is_j    = upper_zero && (op6 == OP_J);
   assign is_halt = upper_zero && (op6 == OP_HALT);
`ifdef MCCTRL_JAL_EN
   assign is_jal  = upper_zero && (op6 == OP_JAL);
`else
   assign is_jal  = 1'b0;
`endif

   assign is_illegal = !(is_add || is_sub || is_addi || is_or || is_ori || is_slt ||
                         is_sw || is_lw || is_beq || is_bne || is_j || is_jal || is_halt);
   assign jump_id    = is_j || is_jal || is_illegal;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q  <= S_IF;
         halted_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_ID && is_halt) begin
            halted_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF:    if (bus.mem_ready && !halted_q) state_d = S_ID;
         S_ID: begin
            if (jump_id || is_halt)      state_d = S_IF;
            else if (is_beq || is_bne)   state_d = S_BEXE;
            else if (is_sw || is_lw)     state_d = S_CEXE;
            else                         state_d = S_AEXE;
         end
         S_AEXE:  state_d = S_AWB;
         S_AWB:   state_d = S_IF;
         S_BEXE:  state_d = S_IF;
         S_CEXE:  state_d = S_MEM;
         S_MEM:   if (bus.mem_ready) state_d = is_lw ? S_CWB : S_IF;
         S_CWB:   state_d = S_IF;
         default: state_d = S_IF;
      endcase
   end

   always_comb begin
      alu_code = 3'b000;
      if (is_sub || is_beq || is_bne) alu_code = 3'b001;
      else if (is_or || is_ori)       alu_code = 3'b101;
      else if (is_slt)                alu_code = 3'b110;
   end

   // Reset forces the idle output pattern even before the state register has been cleared.
   always_comb begin
      reg_wre       = 1'b0;
      bus.state     = S_IF;
      bus.PCWre     = 1'b0;
      bus.InsMemRW  = 1'b1;
      bus.IRWre     = 1'b0;
      bus.WrRegData = 1'b0;
      bus.RegWre    = 1'b0;
      bus.ALUSrcA   = 1'b0;
      bus.ALUSrcB   = 1'b0;
      bus.DataMemRW = 1'b0;
      bus.DBDataSrc = 1'b0;
      bus.ExtSel    = 2'b00;
      bus.RegDst    = 2'b00;
      bus.PCSrc     = 2'b00;
      bus.ALUOp     = '0;
      bus.halted    = 1'b0;
      bus.illegal   = 1'b0;
      if (!Reset) begin
         bus.state     = state_q;
         bus.halted    = halted_q;
         bus.WrRegData = !is_jal;
         bus.ALUSrcB   = is_addi || is_ori || is_lw || is_sw;
         bus.ALUOp     = ALUOP_W'(alu_code);
         if (is_addi || is_lw || is_sw || is_beq || is_bne) bus.ExtSel = 2'b01;
         else if (is_ori)                                   bus.ExtSel = 2'b00;
         else                                               bus.ExtSel = 2'b10;
         case (state_q)
            S_IF:   bus.IRWre = bus.mem_ready && !halted_q;
            S_ID: begin
               bus.PCWre   = jump_id;
               bus.illegal = is_illegal;
               reg_wre     = is_jal;
               if (is_j || is_jal) bus.PCSrc = 2'b11;
            end
            S_BEXE: begin
               bus.PCWre = 1'b1;
               if ((is_beq && bus.zero) || (is_bne && !bus.zero)) bus.PCSrc = 2'b01;
            end
            S_MEM: begin
               if (bus.mem_ready && is_sw) begin
                  bus.PCWre     = 1'b1;
                  bus.DataMemRW = 1'b1;
               end
            end
            S_AWB: begin
               bus.PCWre = 1'b1;
               reg_wre   = 1'b1;
            end
            S_CWB: begin
               bus.PCWre     = 1'b1;
               reg_wre       = 1'b1;
               bus.DBDataSrc = 1'b1;
            end
            default: ;
         endcase
         bus.RegWre = reg_wre;
         // Destination select only matters while a register write is in flight.
         if (reg_wre) begin
            if (is_jal)                          bus.RegDst = 2'b00;
            else if (is_addi || is_ori || is_lw) bus.RegDst = 2'b01;
            else                                 bus.RegDst = 2'b10;
         end
      end
   end

endmodule
